// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter among NUM_REQ packet sources.
// Optional: define UART_TX_SCHED_HDR_EN to prefix every packet with header byte {4'hA, source index}.
module uart_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic [NUM_REQ-1:0]   I_req_valid,
  input  logic [8*NUM_REQ-1:0] I_req_data,
  input  logic [NUM_REQ-1:0]   I_req_last,
  output logic [NUM_REQ-1:0]   O_req_ready,
  output logic                 O_tx_start,
  output logic [7:0]           O_para_data,
  input  logic                 I_tx_done,
  output logic [NUM_REQ-1:0]   O_grant,
  output logic                 O_busy,
  output logic                 O_abort
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FETCH, S_START, S_WAIT, S_GAP
  } state_t;

`ifdef UART_TX_SCHED_HDR_EN
  localparam state_t GRANT_STATE = S_HDR;
`else
  localparam state_t GRANT_STATE = S_FETCH;
`endif
  localparam state_t END_STATE = (GAP_CYC == 0) ? S_IDLE : S_GAP;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic [IW-1:0]        grant_idx_reg, grant_idx_next;
  logic [IW-1:0]        ptr_reg, ptr_next;
  logic [7:0]           data_reg, data_next;
  logic                 last_reg, last_next;
  logic [TW-1:0]        tmo_cnt_reg, tmo_cnt_next;
  logic [GW-1:0]        gap_cnt_reg, gap_cnt_next;
  logic                 tx_start_reg, busy_reg, abort_reg;
`ifdef UART_TX_SCHED_HDR_EN
  logic                 hdr_phase_reg, hdr_phase_next;
`endif

  logic [7:0]           req_data_arr [NUM_REQ];
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   rot_valid;
  logic [IW-1:0]        sel_off, sel_idx;
  logic [IW:0]          sel_sum;
  logic                 sel_found;
  logic                 cur_valid, cur_last;
  logic                 accept, timeout_hit, pkt_end;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi] = I_req_data[8*gi +: 8];
    end
  endgenerate

  // Rotate the valid vector so bit 0 is the source at the priority pointer.
  assign valid_dbl = {I_req_valid, I_req_valid};
  assign rot_valid = valid_dbl[{1'b0, ptr_reg} +: NUM_REQ];

  always_comb begin
    sel_found = 1'b0;
    sel_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        sel_found = 1'b1;
        sel_off   = IW'(k);
      end
    end
    sel_sum = {1'b0, ptr_reg} + {1'b0, sel_off};
    if (sel_sum >= (IW+1)'(NUM_REQ)) begin
      sel_sum = sel_sum - (IW+1)'(NUM_REQ);
    end
    sel_idx = sel_sum[IW-1:0];
  end

  assign cur_valid   = |(grant_reg & I_req_valid);
  assign cur_last    = |(grant_reg & I_req_last);
  assign O_req_ready = (state_reg == S_FETCH) ? (grant_reg & I_req_valid) : '0;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    pkt_end     = 1'b0;
    case (state_reg)
      S_IDLE:  if (sel_found) state_next = GRANT_STATE;
      S_HDR:   state_next = S_START;
      S_FETCH: begin
        if (cur_valid) begin
          accept     = 1'b1;
          state_next = S_START;
        end else if (TIMEOUT_CYC != 0 && tmo_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
          timeout_hit = 1'b1;
          pkt_end     = 1'b1;
          state_next  = END_STATE;
        end
      end
      S_START: state_next = S_WAIT;
      S_WAIT: begin
        if (I_tx_done) begin
`ifdef UART_TX_SCHED_HDR_EN
          if (hdr_phase_reg) begin
            state_next = S_FETCH;
          end else
`endif
          if (last_reg) begin
            pkt_end    = 1'b1;
            state_next = END_STATE;
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      S_GAP:   if (gap_cnt_reg == GW'(GAP_CYC - 1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    grant_next     = grant_reg;
    grant_idx_next = grant_idx_reg;
    ptr_next       = ptr_reg;
    data_next      = data_reg;
    last_next      = last_reg;
    tmo_cnt_next   = '0;
    gap_cnt_next   = '0;
`ifdef UART_TX_SCHED_HDR_EN
    hdr_phase_next = hdr_phase_reg;
    if (state_reg == S_HDR) begin
      data_next      = {4'hA, 4'(grant_idx_reg)};
      hdr_phase_next = 1'b1;
    end
    if (state_reg == S_FETCH) hdr_phase_next = 1'b0;
`endif
    if (state_reg == S_IDLE && sel_found) begin
      grant_next          = '0;
      grant_next[sel_idx] = 1'b1;
      grant_idx_next      = sel_idx;
    end
    if (accept) begin
      data_next = req_data_arr[grant_idx_reg];
      last_next = cur_last;
    end
    if (state_reg == S_FETCH && !cur_valid && TIMEOUT_CYC != 0) tmo_cnt_next = tmo_cnt_reg + 1'b1;
    if (state_reg == S_GAP) gap_cnt_next = gap_cnt_reg + 1'b1;
    // Advance the pointer past the finished owner so the next search starts after it.
    if (pkt_end) begin
      grant_next = '0;
      ptr_next   = (grant_idx_reg == IW'(NUM_REQ - 1)) ? '0 : grant_idx_reg + 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      grant_reg     <= '0;
      grant_idx_reg <= '0;
      ptr_reg       <= '0;
      data_reg      <= 8'h00;
      last_reg      <= 1'b0;
      tmo_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      tx_start_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      abort_reg     <= 1'b0;
`ifdef UART_TX_SCHED_HDR_EN
      hdr_phase_reg <= 1'b0;
`endif
    end else begin
      grant_reg     <= grant_next;
      grant_idx_reg <= grant_idx_next;
      ptr_reg       <= ptr_next;
      data_reg      <= data_next;
      last_reg      <= last_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      tx_start_reg  <= (state_next == S_START);
      busy_reg      <= (state_next != S_IDLE);
      abort_reg     <= timeout_hit;
`ifdef UART_TX_SCHED_HDR_EN
      hdr_phase_reg <= hdr_phase_next;
`endif
    end
  end

  assign O_tx_start  = tx_start_reg;
  assign O_para_data = data_reg;
  assign O_grant     = grant_reg;
  assign O_busy      = busy_reg;
  assign O_abort     = abort_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: sources and TX engine are modelled, every start is checked against a queue.
module tb_uart_tx_sched;

  localparam int NUM = 4;
  localparam int DONE_DLY = 20;
`ifdef UART_TX_SCHED_HDR_EN
  localparam logic [3:0] LAT_RDY = 4'b0000;
`else
  localparam logic [3:0] LAT_RDY = 4'b1000;
`endif

  typedef struct {
    int         src;
    logic [7:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NUM-1:0]   req_valid;
  logic [8*NUM-1:0] req_data;
  logic [NUM-1:0]   req_last;
  logic [NUM-1:0]   req_ready;
  logic             tx_start;
  logic [7:0]       para_data;
  logic             tx_done;
  logic [NUM-1:0]   grant;
  logic             busy;
  logic             abort;
  logic             eng_done, force_done;

  exp_t       exp_q[$];
  logic [8:0] src_q[NUM][$];
  int total = 0, bad = 0;
  int cyc = 0, start_cnt = 0, acc_cnt = 0, abort_cnt = 0;
  int gap_run = 0, last_gap = 0, last_done_cyc = 0, abort_delay = 0;
  bit eng_active = 1'b0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign tx_done = eng_done | force_done;

  uart_tx_sched #(.NUM_REQ(NUM), .GAP_CYC(2), .TIMEOUT_CYC(1024)) dut (
    .I_clk(clk), .I_rst(rst),
    .I_req_valid(req_valid), .I_req_data(req_data), .I_req_last(req_last),
    .O_req_ready(req_ready), .O_tx_start(tx_start), .O_para_data(para_data),
    .I_tx_done(tx_done), .O_grant(grant), .O_busy(busy), .O_abort(abort)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic exp_hdr(input int src);
`ifdef UART_TX_SCHED_HDR_EN
    exp_q.push_back('{src, {4'hA, 4'(src)}});
`endif
  endtask

  task automatic exp_byte(input int src, input logic [7:0] d);
    exp_q.push_back('{src, d});
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NUM; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && busy === 1'b0 && !eng_active && srcs_empty()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check({tag, "_idle_timeout"}, 32'(n), 32'(budget - 1));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_para_data"}, para_data, 8'h00);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_abort"}, abort, 0);
    check({tag, "_ready"}, req_ready, 0);
  endtask

  // Source model: presents the head of each queue, pops on handshake.
  initial begin : sources
    logic [NUM-1:0] hs;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM; i++) begin
        if (hs[i] && src_q[i].size() > 0) begin
          void'(src_q[i].pop_front());
          acc_cnt++;
        end
        if (src_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = src_q[i][0][7:0];
          req_last[i]        = src_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // TX engine model: answers each start with done DONE_DLY cycles later, watching data stability.
  initial begin : engine
    logic [7:0] held;
    bit stable;
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        eng_active = 1'b1;
        held = para_data;
        stable = 1'b1;
        repeat (DONE_DLY - 1) begin
          @(negedge clk);
          if (busy === 1'b1 && rst === 1'b0 && para_data !== held) stable = 1'b0;
        end
        @(posedge clk);
        #1 eng_done = 1'b1;
        @(posedge clk);
        #1 eng_done = 1'b0;
        last_done_cyc = cyc;
        check("para_stable", 32'(stable), 1);
        eng_active = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every start, tracks aborts and GAP length.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_start: got data %02h grant %b, want no start", para_data, grant);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", para_data, e.data);
          check("tx_grant", grant, 32'(1) << e.src);
        end
      end
      if (abort === 1'b1) begin
        abort_cnt++;
        abort_delay = cyc - last_done_cyc;
      end
      if (busy === 1'b1 && grant == '0) begin
        gap_run++;
      end else begin
        if (gap_run != 0) last_gap = gap_run;
        gap_run = 0;
      end
    end
  end

  initial begin : stim
    int a0, s0, n, c0;
    bit rdy_seen;
    rst = 1'b1;
    force_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("init");

    // Source 1 two-byte packet, then a 2-cycle gap with grant cleared.
    a0 = acc_cnt;
    src_q[1].push_back({1'b0, 8'h55});
    src_q[1].push_back({1'b1, 8'hC3});
    exp_hdr(1); exp_byte(1, 8'h55); exp_byte(1, 8'hC3);
    wait_idle(400, "t1");
    check("t1_gap_len", 32'(last_gap), 2);
    check("t1_accepts", 32'(acc_cnt - a0), 2);
    check("t1_grant_idle", grant, 0);

    // Done in IDLE is ignored.
    s0 = start_cnt;
    @(posedge clk); #1 force_done = 1'b1;
    @(posedge clk); #1 force_done = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_done_busy", busy, 0);
    check("idle_done_starts", 32'(start_cnt - s0), 0);

    // Done during START is ignored: no early fetch of the second byte.
    a0 = acc_cnt;
    src_q[0].push_back({1'b0, 8'hA1});
    src_q[0].push_back({1'b1, 8'hA2});
    exp_hdr(0); exp_byte(0, 8'hA1); exp_byte(0, 8'hA2);
    n = 0;
    do begin @(negedge clk); n++; end while (tx_start !== 1'b1 && n < 100);
    check("start_seen", 32'(tx_start), 1);
    force_done = 1'b1;
    @(posedge clk); #1 force_done = 1'b0;
    s0 = start_cnt;
    rdy_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (req_ready != '0) rdy_seen = 1'b1;
    end
    check("start_done_ready", 32'(rdy_seen), 0);
    check("start_done_starts", 32'(start_cnt - s0), 0);
    wait_idle(400, "t2");
    check("t2_accepts", 32'(acc_cnt - a0), 2);

    // Reset mid-WAIT: outputs and pointer return to reset values.
    src_q[2].push_back({1'b1, 8'h5A});
    exp_hdr(2); exp_byte(2, 8'h5A);
    wait_idle(400, "t3a");
    src_q[1].push_back({1'b0, 8'h66});
    src_q[1].push_back({1'b1, 8'h67});
    exp_hdr(1); exp_byte(1, 8'h66);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    check("t3_in_wait_busy", busy, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < NUM; i++) src_q[i].delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("rst_mid");
    n = 0;
    while (eng_active && n < 100) begin @(negedge clk); n++; end
    src_q[0].push_back({1'b1, 8'h01});
    src_q[3].push_back({1'b1, 8'h03});
    exp_hdr(0); exp_byte(0, 8'h01); exp_hdr(3); exp_byte(3, 8'h03);
    wait_idle(400, "t3b");

    // All sources request continuously: strict rotation, wrapping from 3 to 0.
    for (int i = 0; i < NUM; i++) begin
      src_q[i].push_back({1'b1, 8'(i * 16)});
      src_q[i].push_back({1'b1, 8'(i * 16 + 1)});
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM; i++) begin
        exp_hdr(i);
        exp_byte(i, 8'(i * 16 + p));
      end
    end
    wait_idle(2000, "t4");

    // Source 2 stalls mid-packet: abort after 1024 idle FETCH cycles, then source 3.
    a0 = abort_cnt;
    src_q[2].push_back({1'b0, 8'h10});
    src_q[3].push_back({1'b1, 8'h33});
    exp_hdr(2); exp_byte(2, 8'h10); exp_hdr(3); exp_byte(3, 8'h33);
    wait_idle(3000, "t5");
    check("tmo_abort_cnt", 32'(abort_cnt - a0), 1);
    check("tmo_abort_delay", 32'(abort_delay), 1024);

    // Single byte from source 3: ready one cycle after valid, start one cycle later.
    src_q[3].push_back({1'b1, 8'h01});
    exp_hdr(3); exp_byte(3, 8'h01);
    n = 0;
    do begin @(negedge clk); n++; end while (req_valid[3] !== 1'b1 && n < 10);
    c0 = cyc;
    @(negedge clk);
    check("lat_ready", req_ready, LAT_RDY);
    @(negedge clk);
    check("lat_start", 32'(tx_start), 1);
    check("lat_cycles", 32'(cyc - c0), 2);
    wait_idle(400, "t6");

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
